// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks CRC-32 and length, and
// streams the payload with the 4-byte FCS withheld by a 5-deep delay line.
module gmii_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          state, state_nxt;
  logic            dv_q, dv_prev, er_q;
  logic [7:0]      rxd_q;
  logic [2:0]      pre_cnt;
  logic [31:0]     crc;
  logic [15:0]     byte_cnt;
  logic [4:0][7:0] dline;
  logic [2:0]      fill;
  logic            err_seen;

  logic pre_start, pre_step, data_start, pre_drop, data_byte, data_end;
  logic line_full, frame_bad, emit, emit_last, cnt_good, cnt_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // Input capture stage; dv history resets high so a frame already in flight is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q    <= 1'b1;
      dv_prev <= 1'b1;
      er_q    <= 1'b0;
      rxd_q   <= 8'h00;
    end else begin
      dv_q    <= gmii_rx_dv;
      dv_prev <= dv_q;
      er_q    <= gmii_rx_er;
      rxd_q   <= gmii_rxd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (dv_q && !dv_prev) state_nxt = (rxd_q == 8'h55) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!dv_q)                                     state_nxt = IDLE;
        else if (er_q)                                 state_nxt = DROP;
        else if (rxd_q == 8'hD5)                       state_nxt = DATA;
        else if (rxd_q != 8'h55 || pre_cnt == 3'd7)    state_nxt = DROP;
      end
      DATA:     if (!dv_q) state_nxt = IDLE;
      DROP:     if (!dv_q) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pre_start  = (state == IDLE)     && (state_nxt == PREAMBLE);
    pre_step   = (state == PREAMBLE) && (state_nxt == PREAMBLE);
    data_start = (state == PREAMBLE) && (state_nxt == DATA);
    pre_drop   = (state == PREAMBLE) && (state_nxt == DROP);
    data_byte  = (state == DATA) && dv_q;
    data_end   = (state == DATA) && !dv_q;
    line_full  = (fill == 3'd5);
    frame_bad  = (crc != CRC_RESIDUE) || err_seen || (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
    emit       = (data_byte || data_end) && line_full;
    emit_last  = data_end && line_full;
    cnt_good   = emit_last && !frame_bad;
    cnt_bad    = pre_drop || (data_end && (!line_full || frame_bad));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= 3'd0;
      crc       <= 32'hFFFFFFFF;
      byte_cnt  <= 16'h0000;
      dline     <= '0;
      fill      <= 3'd0;
      err_seen  <= 1'b0;
      m_tdata   <= 8'h00;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      stat_good <= 16'h0000;
      stat_bad  <= 16'h0000;
    end else begin
      if (pre_start)     pre_cnt <= 3'd1;
      else if (pre_step) pre_cnt <= pre_cnt + 3'd1;

      if (data_start) begin
        crc      <= 32'hFFFFFFFF;
        byte_cnt <= 16'h0000;
        fill     <= 3'd0;
        err_seen <= 1'b0;
      end else if (data_byte) begin
        crc   <= crc_byte(crc, rxd_q);
        dline <= {dline[3:0], rxd_q};
        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        if (!line_full)           fill     <= fill + 3'd1;
        if (er_q)                 err_seen <= 1'b1;
      end

      // The oldest entry leaves only when a newer byte has arrived, so the FCS stays behind.
      m_tvalid <= emit;
      m_tlast  <= emit_last;
      m_tuser  <= emit_last && frame_bad;
      if (emit) m_tdata <= dline[4];

      if (cnt_good && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
      if (cnt_bad  && stat_bad  != 16'hFFFF) stat_bad  <= stat_bad  + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed + randomized bench for gmii_rx_deframer; expectations come from a
// frame-level model (payload = body minus FCS, FCS compared to CRC of payload).
module tb_gmii_rx_deframer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        gmii_rx_dv = 1'b0, gmii_rx_er = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [15:0] stat_good, stat_bad;

  gmii_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rxd(gmii_rxd), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .stat_good(stat_good), .stat_bad(stat_bad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t got[$];
  int    got_cyc[$];
  beat_t exp_q[$];
  always @(negedge clk) if (m_tvalid === 1'b1) begin
    beat_t b;
    b.data = m_tdata; b.last = m_tlast; b.user = m_tuser;
    got.push_back(b);
    got_cyc.push_back(cyc);
  end

  int passes = 0, total = 0, exp_good = 0, exp_bad = 0;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [31:0] crc32(input bq_t d, input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c ^= {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t mk_body(input bq_t payload);
    bq_t b = payload;
    logic [31:0] f = crc32(payload, payload.size());
    b.push_back(f[7:0]); b.push_back(f[15:8]); b.push_back(f[23:16]); b.push_back(f[31:24]);
    return b;
  endfunction

  function automatic bq_t seq_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'(i));
    return p;
  endfunction

  function automatic bq_t pre(input int n55);
    bq_t p;
    for (int i = 0; i < n55; i++) p.push_back(8'h55);
    p.push_back(8'hD5);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
    step();
  endtask

  task automatic send(input bq_t raw, input int er_idx, input int gap);
    for (int i = 0; i < raw.size(); i++) drive(1'b1, i == er_idx, raw[i]);
    repeat (gap) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Frame-level model: a body of n bytes yields n-4 beats when n >= 5.
  task automatic model(input bq_t body, input bit er);
    int n = body.size();
    bit bad = er || n < MIN_LEN || n > MAX_LEN;
    logic [31:0] fcs;
    if (n < 5) begin exp_bad = sat(exp_bad + 1); return; end
    fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
    if (fcs != crc32(body, n - 4)) bad = 1;
    for (int i = 0; i < n - 4; i++) begin
      beat_t b;
      b.data = body[i]; b.last = (i == n - 5); b.user = (i == n - 5) && bad;
      exp_q.push_back(b);
    end
    if (bad) exp_bad = sat(exp_bad + 1); else exp_good = sat(exp_good + 1);
  endtask

  task automatic check_all(input string tag);
    repeat (6) drive(1'b0, 1'b0, 8'h00);
    chk({tag, "_nbeats"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_beat"}, 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_good"}, stat_good, exp_good);
    chk({tag, "_bad"},  stat_bad,  exp_bad);
    got.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    bq_t v1, body, raw, pl;
    int  n0, nl, eidx;

    repeat (3) step();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast",  m_tlast,  0);
    chk("rst_tuser",  m_tuser,  0);
    chk("rst_good",   stat_good, 0);
    chk("rst_bad",    stat_bad,  0);
    rst = 1'b0;
    step();

    v1 = mk_body(seq_payload(60));

    // V1: good 64-byte frame, plus latency of the first payload byte
    n0 = cyc;
    send({pre(7), v1}, -1, 1);
    model(v1, 0);
    repeat (6) drive(1'b0, 1'b0, 8'h00);
    chk("v1_latency", (got_cyc.size() > 0) ? got_cyc[0] : -1, n0 + 15);
    check_all("v1");

    // V2: payload bit flip
    body = v1; body[10] = body[10] ^ 8'h01;
    send({pre(7), body}, -1, 1); model(body, 0); check_all("v2");

    // V3: rx_er mid-payload, then 40-byte runt with good FCS
    send({pre(7), v1}, 8 + 20, 1); model(v1, 1); check_all("v3_er");
    body = mk_body(seq_payload(36));
    send({pre(7), body}, -1, 1); model(body, 0); check_all("v3_runt");

    // Length boundaries: 63 bad, 1518 good, 1519 bad
    body = mk_body(seq_payload(59));
    send({pre(7), body}, -1, 1); model(body, 0); check_all("len63");
    body = mk_body(seq_payload(1514));
    send({pre(7), body}, -1, 1); model(body, 0); check_all("len_max");
    body = mk_body(seq_payload(1515));
    send({pre(7), body}, -1, 1); model(body, 0); check_all("len_over");

    // V4: back-to-back with a single idle cycle
    send({pre(7), v1}, -1, 1); model(v1, 0);
    send({pre(7), v1}, -1, 1); model(v1, 0);
    check_all("v4_b2b");

    // Preamble faults: 0x54 inside, 8 x 0x55, rx_er, non-0x55 start, early dv drop
    raw = {pre(7), v1}; raw[3] = 8'h54;
    send(raw, -1, 1); exp_bad = sat(exp_bad + 1); check_all("pre_54");
    send({pre(8), v1}, -1, 1); exp_bad = sat(exp_bad + 1); check_all("pre_long");
    send({pre(7), v1}, 4, 1); exp_bad = sat(exp_bad + 1); check_all("pre_er");
    raw = {pre(7), v1}; raw[0] = 8'hD5;
    send(raw, -1, 1); check_all("start_d5");
    raw = {8'h55, 8'h55, 8'h55};
    send(raw, -1, 1); check_all("pre_short");

    // Short bodies: 0 and 3 bytes after SFD
    body = {};
    send({pre(7), body}, -1, 1); model(body, 0); check_all("body0");
    body = seq_payload(3);
    send({pre(7), body}, -1, 1); model(body, 0); check_all("body3");

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      pl = {};
      for (int i = 0, n = $urandom_range(0, 90); i < n; i++) pl.push_back(8'($urandom));
      body = mk_body(pl);
      if ($urandom_range(0, 3) == 0) begin
        int j = $urandom_range(0, body.size() - 1);
        body[j] = body[j] ^ (8'h01 << $urandom_range(0, 7));
      end
      eidx = ($urandom_range(0, 4) == 0) ? 8 + $urandom_range(0, body.size() - 1) : -1;
      send({pre(7), body}, eidx, 1 + $urandom_range(0, 2));
      model(body, eidx >= 0);
    end
    check_all("rand");

    // V5: reset mid-frame with dv held high to the end of that frame
    raw = {pre(7), v1};
    for (int i = 0; i < raw.size(); i++) begin
      rst = (i == 8 + 30);
      drive(1'b1, 1'b0, raw[i]);
    end
    rst = 1'b0;
    repeat (6) drive(1'b0, 1'b0, 8'h00);
    nl = 0;
    foreach (got[i]) if (got[i].last) nl++;
    chk("v5_no_tlast", nl, 0);
    chk("v5_good", stat_good, 0);
    chk("v5_bad",  stat_bad,  0);
    got.delete(); got_cyc.delete();
    exp_good = 0; exp_bad = 0;
    send({pre(7), v1}, -1, 1); model(v1, 0); check_all("v5_after");

    // V6: saturate stat_bad with short preamble drops
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      exp_bad = sat(exp_bad + 1);
      if (i == 65533) begin
        drive(1'b0, 1'b0, 8'h00);
        chk("v6_fffe", stat_bad, exp_bad);
      end
    end
    check_all("v6_sat");
    chk("v6_ffff", stat_bad, 16'hFFFF);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
